// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: command/result bundle between the multicycle control
// and the multiply/divide unit.
//   master : drives start/op/a/b (and acc when MULT_DIV_MADD_EN is defined),
//            mt_we/mt_data; observes busy/done/div_by_zero/hi/lo.
//   slave  : the mult_div_unit side of the same signals.
// Optional feature macro: MULT_DIV_MADD_EN adds the acc command bit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mt_we;
  logic [WIDTH-1:0] mt_data;
`ifdef MULT_DIV_MADD_EN
  logic             acc;
`endif
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
`ifdef MULT_DIV_MADD_EN
    output acc,
`endif
    output start, op, a, b, mt_we, mt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
`ifdef MULT_DIV_MADD_EN
    input  acc,
`endif
    input  start, op, a, b, mt_we, mt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential multiply/divide unit owning the HI/LO pair.
// Serves MULT (op 00), MULTU (01), DIV (10), DIVU (11) with one
// shift-add / restoring shift-subtract iteration per clock, plus direct
// HI/LO writes (MTHI/MTLO).
// Ports:
//   Clk    - clock
//   Reset  - asynchronous, active-high reset
//   bus    - mult_div_unit_if.slave: start/op/a/b command, mt_we/mt_data
//            direct writes, busy/done/div_by_zero status, hi/lo registers.
// Optional feature macro: MULT_DIV_MADD_EN. When defined, bus.acc is sampled
// with start and a multiply accumulates into {hi,lo} (MADD/MADDU).
// Timing: start accepted in IDLE at edge k, done pulses in the cycle after
// edge k+WIDTH+2 (k+1 for a divide by zero); busy covers edges k..k+WIDTH+1.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic           Clk,
  input logic           Reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StFin} state_e;

  state_e stateQ, stateD;

  // Operation context captured at launch
  logic             divQ;      // 1: divide, 0: multiply
  logic             signQ;     // product / quotient must be negated
  logic             remSignQ;  // remainder takes the sign of a
  logic             dbzQ;      // divide by zero, results preloaded
`ifdef MULT_DIV_MADD_EN
  logic             accQ;
`endif
  logic [CNT_W-1:0] cntQ;
  logic [WIDTH-1:0] opndQ;     // multiplicand (mul) or divisor (div) magnitude

  // Multiply: {upper partial sum, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  // Both layouts finish as {hi, lo}.
  logic [2*WIDTH-1:0] prodQ, prodD;

  logic [WIDTH-1:0] hiQ, loQ;

  logic busy, done, launch, resWe, iterate;

  // Launch-time operand decode
  logic             aNeg, bNeg, divIn, divZero;
  logic [WIDTH-1:0] aMag, bMag;

  always_comb begin
    aNeg    = ~bus.op[0] & bus.a[WIDTH-1];
    bNeg    = ~bus.op[0] & bus.b[WIDTH-1];
    aMag    = aNeg ? -bus.a : bus.a;
    bMag    = bNeg ? -bus.b : bus.b;
    divIn   = bus.op[1];
    divZero = divIn && (bus.b == '0);
  end

  assign launch = (stateQ == StIdle) && bus.start;

  // RUN iterates while the counter is non-zero; the cycle it reaches zero
  // hands over to FIX, whose edge both applies the sign fix and writes HI/LO.
  assign iterate = (stateQ == StRun) && !dbzQ && (cntQ != '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (bus.start) stateD = StRun;
      StRun: begin
        if (dbzQ) begin
          stateD = StFin;
        end else if (cntQ == '0) begin
          stateD = StFix;
        end
      end
      StFix:   stateD = StFin;
      StFin:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (stateQ)
      StRun, StFix: busy = 1'b1;
      StFin:        done = 1'b1;
      default:      ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] addSum, remShift, remDiff;

  always_comb begin
    addSum   = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + (prodQ[0] ? {1'b0, opndQ} : '0);
    remShift = {prodQ[2*WIDTH-1:WIDTH], prodQ[WIDTH-1]};
    remDiff  = remShift - {1'b0, opndQ};
    prodD    = prodQ;
    if (iterate) begin
      if (divQ) begin
        // Restoring step: keep the difference only if it did not go negative
        if (!remDiff[WIDTH]) begin
          prodD = {remDiff[WIDTH-1:0], prodQ[WIDTH-2:0], 1'b1};
        end else begin
          prodD = {remShift[WIDTH-1:0], prodQ[WIDTH-2:0], 1'b0};
        end
      end else begin
        prodD = {addSum, prodQ[WIDTH-1:1]};
      end
    end else if (stateQ == StFix) begin
      if (divQ) begin
        prodD[WIDTH-1:0]       = signQ ? -prodQ[WIDTH-1:0] : prodQ[WIDTH-1:0];
        prodD[2*WIDTH-1:WIDTH] = remSignQ ? -prodQ[2*WIDTH-1:WIDTH]
                                          : prodQ[2*WIDTH-1:WIDTH];
      end else if (signQ) begin
        prodD = -prodQ;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      divQ     <= 1'b0;
      signQ    <= 1'b0;
      remSignQ <= 1'b0;
      dbzQ     <= 1'b0;
`ifdef MULT_DIV_MADD_EN
      accQ     <= 1'b0;
`endif
      cntQ     <= '0;
      opndQ    <= '0;
      prodQ    <= '0;
    end else if (launch) begin
      divQ     <= divIn;
      signQ    <= aNeg ^ bNeg;
      remSignQ <= aNeg;
      dbzQ     <= divZero;
`ifdef MULT_DIV_MADD_EN
      accQ     <= bus.acc;
`endif
      cntQ     <= CNT_W'(WIDTH);
      opndQ    <= divIn ? bMag : aMag;
      if (divZero) begin
        // Divide by zero: results are known now, RUN/FIX do nothing
        prodQ <= {bus.a, {WIDTH{1'b1}}};
      end else if (divIn) begin
        prodQ <= {{WIDTH{1'b0}}, aMag};
      end else begin
        prodQ <= {{WIDTH{1'b0}}, bMag};
      end
    end else begin
      prodQ <= prodD;
      if (iterate) begin
        cntQ <= cntQ - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO: result written on the edge entering FIN; MT writes only while not
  // busy, so an MT in the FIN cycle lands after (and over) the result.
  // ---------------------------------------------------------------------------
  assign resWe = (stateD == StFin) && (stateQ != StFin);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hiQ <= '0;
      loQ <= '0;
    end else if (resWe) begin
`ifdef MULT_DIV_MADD_EN
      if (accQ && !divQ) begin
        {hiQ, loQ} <= {hiQ, loQ} + prodD;
      end else begin
        {hiQ, loQ} <= prodD;
      end
`else
      {hiQ, loQ} <= prodD;
`endif
    end else if (!busy) begin
      if (bus.mt_we[1]) hiQ <= bus.mt_data;
      if (bus.mt_we[0]) loQ <= bus.mt_data;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = done & dbzQ;
  assign bus.hi          = hiQ;
  assign bus.lo          = loQ;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {hi,lo},
// div_by_zero and done cycle; a negedge monitor pops on every done.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nTests = 0;
  int   nFail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition
  function automatic logic [63:0] refOp(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic acc,
                                        input logic [63:0] hilo);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          uq = a / b;
          ur = a % b;
          res = {ur, uq};
        end
      end
    endcase
    if (acc && !op[1]) res = res + hilo;
    return res;
  endfunction

  // Called at posedge+#1 with the unit idle; returns at posedge+#1 after edge k
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic acc, input logic [1:0] mtWe, input logic [31:0] mtData);
    sb_t         e;
    logic [63:0] r;
    if (mtWe[1]) mHi = mtData;
    if (mtWe[0]) mLo = mtData;
    r = refOp(op, a, b, acc, {mHi, mLo});
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.dbz = op[1] && (b == 32'd0);
    e.cyc = cyc + 1 + (e.dbz ? 1 : 34);
    sbq.push_back(e);
    {mHi, mLo} = r;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.a       = a;
    bus.b       = b;
    bus.mt_we   = mtWe;
    bus.mt_data = mtData;
`ifdef MULT_DIV_MADD_EN
    bus.acc     = acc;
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mt_we = 2'b00;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL done_timeout: got no done, expected done within 100 cycles");
      sbq.delete();
    end
  endtask

  task automatic mtWrite(input logic [1:0] we, input logic [31:0] data);
    bus.mt_we   = we;
    bus.mt_data = data;
    @(posedge clk);
    #1;
    bus.mt_we = 2'b00;
    if (we[1]) mHi = data;
    if (we[0]) mLo = data;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbq.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("result_hi", {32'd0, bus.hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, bus.lo}, {32'd0, e.lo});
        check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic        racc;
    int          nBusy;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.mt_we = '0; bus.mt_data = '0;
`ifdef MULT_DIV_MADD_EN
    bus.acc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    check("reset_hi", {32'd0, bus.hi}, 64'd0);
    check("reset_lo", {32'd0, bus.lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MULTU max*max with busy duration
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, 32'd0);
    nBusy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) nBusy++;
    end
    @(posedge clk);
    #1;
    check("multu_busy_cycles", 64'(nBusy), 64'd34);
    check("multu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'd0, bus.lo}, 64'h0000_0001);
    waitIdle();

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 2'b00, 32'd0);
    waitIdle();
    check("mult_neg_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_neg_lo", {32'd0, bus.lo}, 64'hFFFF_FFEB);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 2'b00, 32'd0);
    waitIdle();
    check("div_neg_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
    check("div_neg_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);

    issue(2'b11, 32'd100, 32'd7, 1'b0, 2'b00, 32'd0);
    waitIdle();
    check("divu_lo", {32'd0, bus.lo}, 64'd14);
    check("divu_hi", {32'd0, bus.hi}, 64'd2);

    issue(2'b11, 32'h1234, 32'd0, 1'b0, 2'b00, 32'd0);
    waitIdle();
    check("dbz_lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
    check("dbz_hi", {32'd0, bus.hi}, 64'h1234);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b00, 32'd0);
    waitIdle();
    check("div_ovf_lo", {32'd0, bus.lo}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, bus.hi}, 64'd0);

    // Second start mid-run is ignored
    issue(2'b00, 32'd5, 32'd6, 1'b0, 2'b00, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd99; bus.b = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitIdle();
    repeat (5) @(posedge clk);
    #1;
    check("restart_ignored_lo", {32'd0, bus.lo}, 64'd30);

    // MT writes
    mtWrite(2'b10, 32'hCAFE_BABE);
    check("mthi_idle", {32'd0, bus.hi}, 64'hCAFE_BABE);
    issue(2'b01, 32'd3, 32'd5, 1'b0, 2'b00, 32'd0);
    bus.mt_we = 2'b11; bus.mt_data = 32'h1111_1111;
    @(posedge clk);
    #1;
    bus.mt_we = 2'b00;
    check("mt_busy_hi", {32'd0, bus.hi}, 64'hCAFE_BABE);
    waitIdle();
    issue(2'b01, 32'd9, 32'd9, 1'b0, 2'b01, 32'h0000_A5A5);
    check("mt_with_start_lo", {32'd0, bus.lo}, 64'h0000_A5A5);
    waitIdle();
    check("mt_with_start_result", {32'd0, bus.lo}, 64'd81);

`ifdef MULT_DIV_MADD_EN
    mtWrite(2'b10, 32'd0);
    mtWrite(2'b01, 32'd5);
    issue(2'b01, 32'd3, 32'd4, 1'b1, 2'b00, 32'd0);
    waitIdle();
    check("maddu_lo", {32'd0, bus.lo}, 64'd17);
    check("maddu_hi", {32'd0, bus.hi}, 64'd0);
`endif

    // Reset during a MULT
    mtWrite(2'b11, 32'h5555_AAAA);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1234; bus.b = 32'd5678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_busy", {63'd0, bus.busy}, 64'd0);
    check("midreset_hi", {32'd0, bus.hi}, 64'd0);
    check("midreset_lo", {32'd0, bus.lo}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mHi = '0;
    mLo = '0;
    repeat (40) @(posedge clk);
    #1;
    check("postreset_hi", {32'd0, bus.hi}, 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      racc = 1'b0;
`ifdef MULT_DIV_MADD_EN
      racc = 1'($urandom_range(0, 1));
`endif
      issue(rop, ra, rb, racc, 2'b00, 32'd0);
      waitIdle();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
